truth_table_checker: RTL

//   Hardware self-check harness for 3-input/1-output combinational blocks.
//   On start, drives all 8 input vectors {a,b,c}=000..111 into a circuit

---
 rtl/truth_table_checker.sv | 83 ++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Runs all eight {a,b,c} vectors through a 3-input combinational circuit and
// compares its response at the end of each hold against a golden truth table.
module truth_table_checker #(
  parameter logic [7:0] EXPECTED      = 8'h90,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_x,
  output logic       stim_a,
  output logic       stim_b,
  output logic       stim_c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_count
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             miss;

  assign miss = (dut_x != EXPECTED[vec_idx]);
  assign pass = done && (fail_mask == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec_idx    <= 3'd0;
      {stim_a, stim_b, stim_c} <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_mask  <= 8'h00;
      fail_count <= 4'd0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            vec_idx    <= 3'd0;
            {stim_a, stim_b, stim_c} <= 3'b000;
            cnt        <= RELOAD;
            fail_mask  <= 8'h00;
            fail_count <= 4'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        APPLY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Last cycle of the hold: the DUT has had SETTLE_CYCLES to settle.
            if (miss) begin
              fail_mask[vec_idx] <= 1'b1;
              fail_count         <= fail_count + 4'd1;
            end
            if (vec_idx == 3'd7) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_idx                  <= vec_idx + 3'd1;
              {stim_a, stim_b, stim_c} <= vec_idx + 3'd1;
              cnt                      <= RELOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
